// File: rtl/mips_pkg.sv
// mips_pkg - shared opcodes, control-bit indices and MEM-stage state encoding.
// Rev 1.0
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int SIG_MEMRD = 0;
    localparam int SIG_MEMWR = 1;
    localparam int SIG_REGWR = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// load_align - big-endian byte/halfword lane select with sign or zero extension.
// Rev 1.0
`default_nettype none

module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [5:0]  op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage - MIPS memory-access stage: single-outstanding req/ack data port,
// store lane steering, load extraction and upstream stall. Rev 1.0
`default_nettype none

module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_in,
    input  logic [31:0] valB_in,
    input  logic [4:0]  dest_in,
    input  logic [5:0]  op_in,
    input  logic [7:0]  signals_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic [7:0]  wb_signals,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ld_data;
    logic [31:0]      ext_data;
    logic             is_mem;
    logic             is_byte;
    logic             is_half;
    logic             misaligned;
    logic             go;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (alu_in[1:0]),
        .op     (op_in),
        .data   (ext_data)
    );

    always_comb begin
        is_mem     = signals_in[SIG_MEMRD] | signals_in[SIG_MEMWR];
        is_byte    = (op_in == OP_LB) || (op_in == OP_LBU) || (op_in == OP_SB);
        is_half    = (op_in == OP_LH) || (op_in == OP_LHU) || (op_in == OP_SH);
        misaligned = is_half ? alu_in[0] : (!is_byte && (alu_in[1:0] != 2'b00));
        addr_err   = is_mem & misaligned;
        go         = is_mem & ~misaligned;
        stall      = ((state == IDLE) && go) || (state == WAIT);
    end

    // Store data is replicated across lanes; the byte enables pick the target lane.
    always_comb begin
        mem_we   = signals_in[SIG_MEMWR];
        mem_addr = {alu_in[31:2], 2'b00};
        if (is_byte) begin
            mem_wdata = {4{valB_in[7:0]}};
            mem_be    = 4'b1000 >> alu_in[1:0];
        end else if (is_half) begin
            mem_wdata = {2{valB_in[15:0]}};
            mem_be    = alu_in[1] ? 4'b0011 : 4'b1100;
        end else begin
            mem_wdata = valB_in;
            mem_be    = 4'b1111;
        end
    end

    always_comb begin
        wb_data    = ((state == DONE) && signals_in[SIG_MEMRD]) ? ld_data : alu_in;
        wb_dest    = dest_in;
        wb_signals = signals_in;
        wb_signals[SIG_REGWR] = signals_in[SIG_REGWR] & ~(addr_err | bus_err);
    end

    // DONE always falls back to IDLE: the upstream buffer advances on that edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            ld_data <= '0;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= WAIT;
                        mem_req <= 1'b1;
                        cnt     <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        ld_data <= ext_data;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
